mem_ram_dp: RTL

Parametrised true-dual-port data RAM for the core's load/store path, replacing the single-port byte-masked RAM. Each port does masked word writes or reads with a fixed, configurable read latency. After every reset the block zero-clears its whole array with an internal sequencer. Collisions between ports are resolved deterministically. Port A serves the LSU and port B serves the debug/DMA side.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_ram_port.sv | 120 ++++++++++++
 rtl/mem_ram_dp.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the dual-port data RAM: FSM states, latency
// limits and the per-byte merge used by the write and bypass paths.
package mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int RL_MIN = 1;
    localparam int RL_MAX = 2;

    // Widest word the merge helper handles; narrower words are size-cast in and out.
    localparam int MERGE_W  = 256;
    localparam int MERGE_MW = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] mask_merge(
        input logic [MERGE_W-1:0]  old_w,
        input logic [MERGE_W-1:0]  new_w,
        input logic [MERGE_MW-1:0] mask
    );
        logic [MERGE_W-1:0] res;
        for (int i = 0; i < MERGE_MW; i++) begin
            res[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_ram_port.sv
// One RAM port: request decode, address range check, optional same-port
// write bypass and the 1- or 2-stage read pipeline with held output data.
module mem_ram_port
    import mem_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 1024,
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 0,
    localparam int MW          = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ready_i,
    input  logic              en_n,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic [MW-1:0]     wr_mask_i,
    input  logic [DATA_W-1:0] rd_word_i,
    output logic [ADDR_W-1:0] idx_o,
    output logic [MW-1:0]     wr_en_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [DATA_W-1:0] data_out_o,
    output logic              valid_o,
    output logic              err_o
);

    localparam bit BYPASS = (READ_LATENCY == 2) && (WRITE_FIRST != 0);

    function automatic logic [DATA_W-1:0] merge_w(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [MW-1:0]     mask
    );
        return DATA_W'(mask_merge(MERGE_W'(old_w), MERGE_W'(new_w), MERGE_MW'(mask)));
    endfunction

    logic acc, in_range, is_rd, rd_acc;
    logic [DATA_W-1:0] rd_word;

    assign acc       = ready_i && !en_n;
    assign in_range  = 32'(address_i) < DEPTH;
    assign is_rd     = (wr_mask_i == '0);
    assign rd_acc    = acc && is_rd;
    // Out-of-range addresses are steered to word 0 so the array index stays legal.
    assign idx_o     = in_range ? address_i : '0;
    assign wr_en_o   = (acc && in_range) ? wr_mask_i : '0;
    assign wr_data_o = data_in_i;

    generate
        if (BYPASS) begin : g_byp
            logic              wr_vld_p1;
            logic [ADDR_W-1:0] wr_addr_p1;
            logic [DATA_W-1:0] wr_data_p1;
            logic [MW-1:0]     wr_mask_p1;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) wr_vld_p1 <= 1'b0;
                else          wr_vld_p1 <= (wr_en_o != '0);
            end

            always_ff @(posedge clk) begin
                wr_addr_p1 <= address_i;
                wr_data_p1 <= data_in_i;
                wr_mask_p1 <= wr_mask_i;
            end

            assign rd_word = (wr_vld_p1 && wr_addr_p1 == address_i)
                           ? merge_w(rd_word_i, wr_data_p1, wr_mask_p1) : rd_word_i;
        end else begin : g_nobyp
            assign rd_word = rd_word_i;
        end
    endgenerate

    // Stage p1: array sampled at the accepting edge
    logic              vld_p1, err_p1;
    logic [DATA_W-1:0] data_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= rd_acc;
            err_p1 <= rd_acc && !in_range;
            if (rd_acc) data_p1 <= in_range ? rd_word : '0;
        end
    end

    // Stage p2: extra output register when READ_LATENCY is 2
    generate
        if (READ_LATENCY == 2) begin : g_p2
            logic              vld_p2, err_p2;
            logic [DATA_W-1:0] data_p2;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    vld_p2  <= 1'b0;
                    err_p2  <= 1'b0;
                    data_p2 <= '0;
                end else begin
                    vld_p2 <= vld_p1;
                    err_p2 <= err_p1;
                    if (vld_p1) data_p2 <= data_p1;
                end
            end

            assign data_out_o = data_p2;
            assign valid_o    = vld_p2;
            assign err_o      = err_p2;
        end else begin : g_p1
            assign data_out_o = data_p1;
            assign valid_o    = vld_p1;
            assign err_o      = err_p1;
        end
    endgenerate

endmodule

// File: rtl/mem_ram_dp.sv
// True dual-port data RAM (A = LSU, B = debug/DMA) with a post-reset zero-clear
// sequencer and byte-wise collision merge where port A wins shared bytes.
module mem_ram_dp
    import mem_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 0,
    localparam int ADDR_W      = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
    localparam int MW          = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_en_n,
    input  logic [ADDR_W-1:0] a_address_i,
    input  logic [DATA_W-1:0] a_data_in_i,
    input  logic [MW-1:0]     a_wr_mask_i,
    output logic [DATA_W-1:0] a_data_out_o,
    output logic              a_valid_o,
    output logic              a_err_o,
    input  logic              b_en_n,
    input  logic [ADDR_W-1:0] b_address_i,
    input  logic [DATA_W-1:0] b_data_in_i,
    input  logic [MW-1:0]     b_wr_mask_i,
    output logic [DATA_W-1:0] b_data_out_o,
    output logic              b_valid_o,
    output logic              b_err_o,
    output logic              init_done_o
);

    generate
        if (READ_LATENCY < RL_MIN || READ_LATENCY > RL_MAX) begin : g_bad_rl
            $error("mem_ram_dp: READ_LATENCY must be 1 or 2");
        end
        if ((DATA_W % 8) != 0 || DATA_W > MERGE_W || DEPTH < 2) begin : g_bad_geom
            $error("mem_ram_dp: unsupported DATA_W or DEPTH");
        end
    endgenerate

    function automatic logic [DATA_W-1:0] merge_w(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [MW-1:0]     mask
    );
        return DATA_W'(mask_merge(MERGE_W'(old_w), MERGE_W'(new_w), MERGE_MW'(mask)));
    endfunction

    state_t            state, state_n;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_n;
    logic              ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_n;
            clr_cnt <= clr_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        clr_cnt_n = clr_cnt;
        if (state == ST_CLEAR) begin
            if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                state_n   = ST_READY;
                clr_cnt_n = '0;
            end else begin
                clr_cnt_n = clr_cnt + ADDR_W'(1);
            end
        end
    end

    assign ready       = (state == ST_READY);
    assign init_done_o = ready;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] a_idx, b_idx;
    logic [MW-1:0]     a_we, b_we;
    logic [DATA_W-1:0] a_wdata, b_wdata, a_rd, b_rd, a_word, b_word;

    assign a_rd   = mem[a_idx];
    assign b_rd   = mem[b_idx];
    // On a same-word collision A merges on top of B's result, so A owns shared bytes.
    assign b_word = merge_w(b_rd, b_wdata, b_we);
    assign a_word = merge_w((b_we != '0 && b_idx == a_idx) ? b_word : a_rd, a_wdata, a_we);

    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[clr_cnt] <= '0;
        end else begin
            if (b_we != '0) mem[b_idx] <= b_word;
            if (a_we != '0) mem[a_idx] <= a_word;
        end
    end

    mem_ram_port #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .READ_LATENCY(READ_LATENCY), .WRITE_FIRST(WRITE_FIRST)
    ) u_port_a (
        .clk(clk), .reset_n(reset_n), .ready_i(ready),
        .en_n(a_en_n), .address_i(a_address_i), .data_in_i(a_data_in_i),
        .wr_mask_i(a_wr_mask_i), .rd_word_i(a_rd),
        .idx_o(a_idx), .wr_en_o(a_we), .wr_data_o(a_wdata),
        .data_out_o(a_data_out_o), .valid_o(a_valid_o), .err_o(a_err_o)
    );

    mem_ram_port #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .READ_LATENCY(READ_LATENCY), .WRITE_FIRST(WRITE_FIRST)
    ) u_port_b (
        .clk(clk), .reset_n(reset_n), .ready_i(ready),
        .en_n(b_en_n), .address_i(b_address_i), .data_in_i(b_data_in_i),
        .wr_mask_i(b_wr_mask_i), .rd_word_i(b_rd),
        .idx_o(b_idx), .wr_en_o(b_we), .wr_data_o(b_wdata),
        .data_out_o(b_data_out_o), .valid_o(b_valid_o), .err_o(b_err_o)
    );

endmodule
